// File: rtl/trapez_peak_sampler_pkg.sv
// Shared types and default parameters for the trapezoid peak sampler.
// Holds the FSM state encoding, the status code and the shaper geometry defaults.
package trapez_peak_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RISE     = 3'd1,
    ST_FLAT     = 3'd2,
    ST_FALL     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t STATUS_GOOD   = 2'b00;
  localparam status_t STATUS_SHORT  = 2'b01;
  localparam status_t STATUS_PILEUP = 2'b10;

  localparam int RISE_LEN_DEF      = 25;
  localparam int FLAT_LEN_DEF      = 20;
  localparam int WIN_START_DEF     = 3;
  localparam int AVG_LOG2_DEF      = 3;
  localparam int PILEUP_MARGIN_DEF = 8;
  localparam int DIN_W_DEF         = 26;
  localparam int DOUT_W_DEF        = 16;

endpackage

// File: rtl/trapez_flat_top_averager.sv
// Flat-top accumulator: sums the window samples, then divides by the window size
// with an arithmetic shift and clamps the result to the output word range.
module trapez_flat_top_averager
  import trapez_peak_sampler_pkg::*;
#(
  parameter int DIN_W    = DIN_W_DEF,
  parameter int DOUT_W   = DOUT_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              acc_en,
  input  logic [DIN_W-1:0]  sample,
  output logic [DOUT_W-1:0] avg
);

  localparam int ACC_W = DIN_W + AVG_LOG2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] sample_ext_s;
  logic signed [ACC_W-1:0] shifted_s;

  function automatic logic [DOUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [DOUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(DOUT_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(DOUT_W-1){1'b0}}};
    end else begin
      r = v[DOUT_W-1:0];
    end
    return r;
  endfunction

  assign sample_ext_s = ACC_W'($signed(sample));
  // Arithmetic shift floors toward -inf, so -8001/8 becomes -1001.
  assign shifted_s    = acc_r >>> AVG_LOG2;
  assign avg          = saturate(shifted_s);

  // Accumulator: clear wins over accumulate so an emission cycle always starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (acc_en) begin
      acc_r <= acc_r + sample_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/trapez_peak_sampler.sv
// Pulse-height stage behind the trapezoidal shaper: tracks rise, flat top and fall,
// averages a flat-top window and emits one amplitude plus status per event.
module trapez_peak_sampler
  import trapez_peak_sampler_pkg::*;
#(
  parameter int RISE_LEN      = RISE_LEN_DEF,
  parameter int FLAT_LEN      = FLAT_LEN_DEF,
  parameter int WIN_START     = WIN_START_DEF,
  parameter int AVG_LOG2      = AVG_LOG2_DEF,
  parameter int PILEUP_MARGIN = PILEUP_MARGIN_DEF,
  parameter int DIN_W         = DIN_W_DEF,
  parameter int DOUT_W        = DOUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIN_W-1:0]  shaper_data,
  input  logic              shaper_data_valid,
  input  logic [DIN_W-1:0]  threshold,
  output logic [DOUT_W-1:0] peak_data,
  output logic [1:0]        peak_status,
  output logic              peak_valid,
  output logic              busy,
  output logic [15:0]       event_count
);

  localparam int CNT_W = $clog2(RISE_LEN + FLAT_LEN + PILEUP_MARGIN + 2);
  localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(WIN_START);
  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(WIN_START + (1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_LEN - 1);
  localparam logic [CNT_W-1:0] FLAT_LAST = CNT_W'(FLAT_LEN - 1);
  localparam logic [CNT_W-1:0] FALL_MAX  = CNT_W'(RISE_LEN + PILEUP_MARGIN);

  if (WIN_START + (1 << AVG_LOG2) > FLAT_LEN) begin : g_win_check
    $error("averaging window does not fit inside the flat top");
  end

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DOUT_W-1:0] peak_data_r;
  status_t           peak_status_r;
  logic              peak_valid_r;
  logic              busy_r;
  logic [15:0]       event_count_r;

  logic              above_s;
  logic              in_win_s;
  logic              emit_s;
  logic              acc_en_s;
  logic              clear_s;
  logic [DOUT_W-1:0] avg_s;

  assign above_s  = $signed(shaper_data) > $signed(threshold);
  assign in_win_s = (cnt_r >= WIN_LO) && (cnt_r <= WIN_HI);
  assign clear_s  = !enable || emit_s;

  // Decode terminating samples and window accumulation for the current valid sample.
  always_comb begin
    emit_s   = 1'b0;
    acc_en_s = 1'b0;
    if (enable && shaper_data_valid) begin
      case (state_r)
        ST_RISE, ST_FLAT, ST_FALL, ST_WAIT_LOW: emit_s = !above_s;
        default:                                emit_s = 1'b0;
      endcase
      acc_en_s = (state_r == ST_FLAT) && above_s && in_win_s;
    end else begin
      emit_s   = 1'b0;
      acc_en_s = 1'b0;
    end
  end

  trapez_flat_top_averager #(
    .DIN_W    (DIN_W),
    .DOUT_W   (DOUT_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_averager (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_s),
    .acc_en  (acc_en_s),
    .sample  (shaper_data),
    .avg     (avg_s)
  );

  // Event FSM with phase counter and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      peak_data_r   <= '0;
      peak_status_r <= STATUS_GOOD;
      peak_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      event_count_r <= 16'd0;
    end else begin
      peak_valid_r <= 1'b0;
      if (!enable) begin
        state_r <= ST_IDLE;
        cnt_r   <= '0;
        busy_r  <= 1'b0;
      end else if (shaper_data_valid) begin
        case (state_r)
          ST_IDLE: begin
            if (above_s) begin
              busy_r <= 1'b1;
              if (RISE_LEN <= 1) begin
                state_r <= ST_FLAT;
                cnt_r   <= '0;
              end else begin
                state_r <= ST_RISE;
                cnt_r   <= CNT_W'(1);
              end
            end
          end
          ST_RISE, ST_FLAT: begin
            if (!above_s) begin
              state_r       <= ST_IDLE;
              cnt_r         <= '0;
              busy_r        <= 1'b0;
              peak_valid_r  <= 1'b1;
              peak_data_r   <= '0;
              peak_status_r <= STATUS_SHORT;
            end else if (state_r == ST_RISE && cnt_r == RISE_LAST) begin
              state_r <= ST_FLAT;
              cnt_r   <= '0;
            end else if (state_r == ST_FLAT && cnt_r == FLAT_LAST) begin
              state_r <= ST_FALL;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_FALL: begin
            if (!above_s) begin
              state_r       <= ST_IDLE;
              cnt_r         <= '0;
              busy_r        <= 1'b0;
              peak_valid_r  <= 1'b1;
              peak_data_r   <= avg_s;
              peak_status_r <= STATUS_GOOD;
              event_count_r <= event_count_r + 16'd1;
            end else if (cnt_r >= FALL_MAX) begin
              // Fall is longer than any clean trapezoid could be: a second pulse piled up.
              state_r <= ST_WAIT_LOW;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_WAIT_LOW: begin
            if (!above_s) begin
              state_r       <= ST_IDLE;
              cnt_r         <= '0;
              busy_r        <= 1'b0;
              peak_valid_r  <= 1'b1;
              peak_data_r   <= avg_s;
              peak_status_r <= STATUS_PILEUP;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign peak_data   = peak_data_r;
  assign peak_status = peak_status_r;
  assign peak_valid  = peak_valid_r;
  assign busy        = busy_r;
  assign event_count = event_count_r;

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// Directed bench for trapez_peak_sampler: a table of synthetic trapezoids with
// hand-computed results, followed by enable and reset corner sequences.
module tb_trapez_peak_sampler;

  localparam int RISE = 25;
  localparam int FLAT = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [25:0] shaper_data;
  logic        shaper_data_valid;
  logic [25:0] threshold;
  logic [15:0] peak_data;
  logic [1:0]  peak_status;
  logic        peak_valid;
  logic        busy;
  logic [15:0] event_count;

  always #5 clk = ~clk;

  trapez_peak_sampler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .shaper_data       (shaper_data),
    .shaper_data_valid (shaper_data_valid),
    .threshold         (threshold),
    .peak_data         (peak_data),
    .peak_status       (peak_status),
    .peak_valid        (peak_valid),
    .busy              (busy),
    .event_count       (event_count)
  );

  typedef struct {
    int          thr;
    int          rise_start;
    int          rise_step;
    int          rise_n;
    int          flat_val;
    int          flat_mode;
    int          flat_n;
    int          fall_start;
    int          fall_step;
    int          fall_n;
    int          base;
    bit          gap;
    logic [15:0] exp_data;
    logic [1:0]  exp_stat;
  } vec_t;

  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  int          pv_n = 0;
  logic [15:0] got_data = 16'd0;
  logic [1:0]  got_stat = 2'd0;
  logic        got_busy = 1'b0;
  logic [15:0] exp_count = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given input, then record any result strobe.
  task automatic step(input logic [25:0] d, input logic v);
    shaper_data       = d;
    shaper_data_valid = v;
    @(posedge clk);
    #1;
    if (peak_valid === 1'b1) begin
      pv_n++;
      got_data = peak_data;
      got_stat = peak_status;
      got_busy = busy;
    end
  endtask

  task automatic sample(input int d, input bit gap);
    step(26'(d), 1'b1);
    if (gap) step(26'($urandom), 1'b0);
  endtask

  function automatic int flat_dev(input int mode, input int k);
    case (mode)
      1: return ((k % 4) == 0) ? 10 : ((k % 4) == 1) ? -10 : ((k % 4) == 2) ? 7 : -7;
      2: return (k == 3) ? -1 : 0;
      3: return (k == 2 || k == 11) ? 4000 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    threshold = 26'(v.thr);
    step(26'(v.base), 1'b1);
    pv_n = 0;
    for (int i = 0; i < v.rise_n; i++) begin
      sample(v.rise_start + v.rise_step * i, v.gap);
      if (i == 0) check($sformatf("v%0d_busy_rise", idx), 32'(busy), 32'd1);
    end
    if (v.rise_n == RISE) begin
      for (int k = 0; k < v.flat_n; k++) sample(v.flat_val + flat_dev(v.flat_mode, k), v.gap);
      if (v.flat_n == FLAT) begin
        for (int j = 0; j < v.fall_n; j++) sample(v.fall_start + v.fall_step * j, v.gap);
      end
    end
    check($sformatf("v%0d_no_early", idx), 32'(pv_n), 32'd0);
    step(26'(v.base), 1'b1);
    if (v.exp_stat == 2'b00) exp_count = exp_count + 16'd1;
    check($sformatf("v%0d_nvalid", idx), 32'(pv_n), 32'd1);
    check($sformatf("v%0d_data", idx), 32'(got_data), 32'(v.exp_data));
    check($sformatf("v%0d_status", idx), 32'(got_stat), 32'(v.exp_stat));
    check($sformatf("v%0d_busy_emit", idx), 32'(got_busy), 32'd0);
    check($sformatf("v%0d_count", idx), 32'(event_count), 32'(exp_count));
    step(26'(v.base), 1'b0);
    check($sformatf("v%0d_valid_1cyc", idx), 32'(peak_valid), 32'd0);
    check($sformatf("v%0d_data_hold", idx), 32'(peak_data), 32'(v.exp_data));
  endtask

  initial begin
    //          thr     rstart  rstep rn  flat    fm fn  fstart  fstep fn  base    gap exp       stat
    vecs[0]  = '{30,     40,     40,  25, 1000,   0, 20, 960,    -40,  24, 0,      0, 16'd1000, 2'b00};
    vecs[1]  = '{30,     40,     40,  25, 1000,   1, 20, 960,    -40,  24, 0,      0, 16'd1000, 2'b00};
    vecs[2]  = '{30,     40,     40,  25, 1000,   1, 20, 960,    -40,  24, 0,      1, 16'd1000, 2'b00};
    vecs[3]  = '{30,     40,     40,  9,  1000,   0, 20, 960,    -40,  24, 0,      0, 16'd0,    2'b01};
    vecs[4]  = '{30,     40,     40,  25, 1000,   0, 7,  960,    -40,  24, 0,      0, 16'd0,    2'b01};
    vecs[5]  = '{30,     40,     40,  25, 1001,   0, 20, 500,    0,    33, 30,     0, 16'd1001, 2'b00};
    vecs[6]  = '{30,     40,     40,  25, 1000,   0, 20, 500,    0,    34, 30,     0, 16'd1000, 2'b10};
    vecs[7]  = '{30,     40,     40,  25, 1000,   0, 20, 500,    0,    40, 30,     0, 16'd1000, 2'b10};
    vecs[8]  = '{30,     40000,  0,   25, 40000,  0, 20, 40000,  0,    1,  0,      0, 16'h7FFF, 2'b00};
    vecs[9]  = '{-50000, -40000, 0,   25, -40000, 0, 20, -40000, 0,    1,  -60000, 0, 16'h8000, 2'b00};
    vecs[10] = '{-2000,  -1000,  0,   25, -1000,  2, 20, 0,      0,    0,  -3000,  0, 16'hFC17, 2'b00};
    vecs[11] = '{30,     40,     40,  25, 1000,   3, 20, 960,    -40,  24, 0,      1, 16'd1000, 2'b00};

    reset_n           = 1'b0;
    enable            = 1'b1;
    shaper_data       = 26'd0;
    shaper_data_valid = 1'b0;
    threshold         = 26'd30;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(peak_data), 32'd0);
    check("rst_status", 32'(peak_status), 32'd0);
    check("rst_valid", 32'(peak_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(event_count), 32'd0);
    reset_n = 1'b1;
    step(26'd0, 1'b0);

    for (int v = 0; v < 12; v++) run_vec(vecs[v], v);

    // enable dropped in the middle of the flat top
    threshold = 26'd30;
    step(26'd0, 1'b1);
    pv_n = 0;
    for (int i = 0; i < RISE; i++) sample(40 + 40 * i, 1'b0);
    for (int k = 0; k < 5; k++) sample(1000, 1'b0);
    check("en_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    step(26'd1000, 1'b1);
    check("en_busy_off", 32'(busy), 32'd0);
    step(26'd1000, 1'b1);
    check("en_idle_hold", 32'(busy), 32'd0);
    enable = 1'b1;
    step(26'd0, 1'b1);
    check("en_no_emit", 32'(pv_n), 32'd0);
    check("en_count_hold", 32'(event_count), 32'(exp_count));
    run_vec(vecs[0], 12);

    // asynchronous reset in the middle of the fall
    step(26'd0, 1'b1);
    for (int i = 0; i < RISE; i++) sample(40 + 40 * i, 1'b0);
    for (int k = 0; k < FLAT; k++) sample(1000, 1'b0);
    for (int j = 0; j < 5; j++) sample(960 - 40 * j, 1'b0);
    check("rstf_busy_before", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("rstf_data", 32'(peak_data), 32'd0);
    check("rstf_status", 32'(peak_status), 32'd0);
    check("rstf_valid", 32'(peak_valid), 32'd0);
    check("rstf_busy", 32'(busy), 32'd0);
    check("rstf_count", 32'(event_count), 32'd0);
    exp_count = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    pv_n = 0;
    step(26'd0, 1'b1);
    step(26'd0, 1'b1);
    check("rstf_no_partial", 32'(pv_n), 32'd0);
    run_vec(vecs[0], 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
